// File: rtl/avl_burst_arbiter.sv
// Two-master Avalon-MM burst arbiter sharing one slave port.
// Round-robin grant taken in IDLE; the owner keeps the slave until its
// latched burst completes (write beats accepted or read returns drained).
//
// Handshake: a master command or write beat is transferred on a rising
// edge where that master drives read/write = 1 and sees waitrequest = 0.
// Read data returns on mN_readdatavalid with no backpressure.
module avl_burst_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int BCNT_W = 10
) (
  input  logic              avl_clk,
  input  logic              avl_rst,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BCNT_W-1:0] m0_burstcount,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic              m0_beginbursttransfer,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BCNT_W-1:0] m1_burstcount,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic              m1_beginbursttransfer,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BCNT_W-1:0] s_burstcount,
  output logic              s_read,
  output logic              s_write,
  output logic              s_beginbursttransfer,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_CMD   = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

  localparam logic [BCNT_W-1:0] ONE = {{(BCNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;      // index of the most recent finished owner
  logic [BCNT_W-1:0] len_m1_q, len_m1_d;  // latched burst length minus one
  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic              begin_q, begin_d;

  logic              owner;
  logic              own_write;
  logic              own_ready;
  logic              req0, req1, sel;
  logic              sel_write, sel_begin;
  logic [BCNT_W-1:0] sel_bcnt, sel_len;

  assign owner     = grant_q[1];
  assign own_write = owner ? m1_write : m0_write;

  // Arbitration: a lone requester wins, a tie goes to the master not served last.
  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign sel       = (req0 & req1) ? ~last_q : req1;
  assign sel_write = sel ? m1_write : m0_write;
  assign sel_begin = sel ? m1_beginbursttransfer : m0_beginbursttransfer;
  assign sel_bcnt  = sel ? m1_burstcount : m0_burstcount;
  assign sel_len   = (sel_begin && sel_bcnt != '0) ? sel_bcnt : ONE;

  // Slave command fields follow the current owner live.
  assign s_address    = owner ? m1_address : m0_address;
  assign s_writedata  = owner ? m1_writedata : m0_writedata;
  assign s_burstcount = owner ? m1_burstcount : m0_burstcount;

  // Read returns: data is an ungated pass-through, valid only to the draining owner.
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = (state_q == RD_DRAIN) & s_readdatavalid & grant_q[0];
  assign m1_readdatavalid = (state_q == RD_DRAIN) & s_readdatavalid & grant_q[1];

  assign m0_waitrequest = ~(own_ready & grant_q[0]);
  assign m1_waitrequest = ~(own_ready & grant_q[1]);

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign fsm_state = state_q;

  // State, grant, pointer and burst bookkeeping registers.
  always_ff @(posedge avl_clk or posedge avl_rst) begin
    if (avl_rst) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;
      len_m1_q <= '0;
      cnt_q    <= '0;
      begin_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      len_m1_q <= len_m1_d;
      cnt_q    <= cnt_d;
      begin_q  <= begin_d;
    end
  end

  // Next-state and slave strobe decode.
  always_comb begin
    state_d              = state_q;
    grant_d              = grant_q;
    last_d               = last_q;
    len_m1_d             = len_m1_q;
    cnt_d                = cnt_q;
    begin_d              = begin_q;
    own_ready            = 1'b0;
    s_read               = 1'b0;
    s_write              = 1'b0;
    s_beginbursttransfer = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = 2'b00;
        cnt_d   = '0;
        if (req0 | req1) begin
          grant_d  = sel ? 2'b10 : 2'b01;
          begin_d  = sel_begin;
          len_m1_d = sel_len - ONE;
          state_d  = sel_write ? WR_BURST : RD_CMD;
        end
      end
      WR_BURST: begin
        own_ready = 1'b1;
        if (own_write) begin
          s_write              = 1'b1;
          s_beginbursttransfer = (cnt_q == '0);
          if (cnt_q == len_m1_q) begin
            state_d = IDLE;
            grant_d = 2'b00;
            cnt_d   = '0;
            last_d  = owner;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      RD_CMD: begin
        own_ready            = 1'b1;
        s_read               = 1'b1;
        s_beginbursttransfer = begin_q;
        state_d              = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (s_readdatavalid) begin
          if (cnt_q == len_m1_q) begin
            state_d = IDLE;
            grant_d = 2'b00;
            cnt_d   = '0;
            last_d  = owner;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_avl_burst_arbiter.sv
// Directed bench for avl_burst_arbiter: a slave memory model, per-master
// driver tasks, and a transaction-level scoreboard (expected grant order,
// expected slave write beats, read commands and per-master read returns).
module tb_avl_burst_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int BW = 10;

  logic          avl_clk, avl_rst;
  logic [AW-1:0] m0_address, m1_address;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic [BW-1:0] m0_burstcount, m1_burstcount;
  logic          m0_read, m0_write, m0_beginbursttransfer;
  logic          m1_read, m1_write, m1_beginbursttransfer;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] s_address;
  logic [DW-1:0] s_writedata;
  logic [BW-1:0] s_burstcount;
  logic          s_read, s_write, s_beginbursttransfer;
  logic [DW-1:0] s_readdata;
  logic          s_readdatavalid;
  logic [1:0]    grant;
  logic          busy;
  logic [1:0]    fsm_state;

  avl_burst_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BCNT_W(BW)) dut (
    .avl_clk(avl_clk), .avl_rst(avl_rst),
    .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_burstcount(m0_burstcount),
    .m0_read(m0_read), .m0_write(m0_write), .m0_beginbursttransfer(m0_beginbursttransfer),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_burstcount(m1_burstcount),
    .m1_read(m1_read), .m1_write(m1_write), .m1_beginbursttransfer(m1_beginbursttransfer),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_writedata(s_writedata), .s_burstcount(s_burstcount),
    .s_read(s_read), .s_write(s_write), .s_beginbursttransfer(s_beginbursttransfer),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .grant(grant), .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    avl_clk = 1'b0;
    forever #5 avl_clk = ~avl_clk;
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+DW:0] exp_wr_q[$];     // {address, writedata, begin}
  logic [AW:0]    exp_rd_q[$];     // {address, begin}
  logic [DW-1:0]  exp_m0_q[$];
  logic [DW-1:0]  exp_m1_q[$];
  logic [0:0]     exp_grant_q[$];  // owner index in grant order
  logic [0:0]     grant_log[$];
  int             wr_beats = 0;
  int             begin_beats = 0;
  int             rdv_pulses = 0;
  int             stray_req = 0;
  logic [AW-1:0]  slv_rd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s at %0t", name, msg, $time);
  endtask

  // ---------------- slave memory model ----------------
  initial begin
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          cw, cr, cbeg, ph;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic [BW-1:0] cb;
    int            len;
    int            stray_seen;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    mem[10'h200] = 8'h11; mem[10'h201] = 8'h22; mem[10'h202] = 8'h33;
    mem[10'h010] = 8'h31; mem[10'h011] = 8'h32; mem[10'h012] = 8'h33;
    s_readdatavalid = 1'b0;
    s_readdata      = '0;
    ph              = 1'b1;
    stray_seen      = 0;
    forever begin
      @(negedge avl_clk);
      cw = s_write; cr = s_read; ca = s_address; cd = s_writedata;
      cb = s_burstcount; cbeg = s_beginbursttransfer;
      @(posedge avl_clk);
      #1;
      if (cw) mem[ca] = cd;
      if (cr) begin
        len = (cbeg && cb != '0) ? int'(cb) : 1;
        for (int j = 0; j < len; j++) slv_rd_q.push_back(ca + AW'(j));
      end
      s_readdatavalid = 1'b0;
      if (stray_seen != stray_req) begin
        stray_seen++;
        s_readdatavalid = 1'b1;
        s_readdata      = 8'hEE;
      end else if (slv_rd_q.size() > 0 && ph) begin
        s_readdatavalid = 1'b1;
        s_readdata      = mem[slv_rd_q.pop_front()];
      end
      ph = ~ph;
    end
  end

  // ---------------- per-cycle compare process ----------------
  initial begin
    logic [1:0]    prev_g;
    logic [0:0]    g;
    logic [AW+DW:0] ew;
    logic [AW:0]   er;
    prev_g = 2'b00;
    forever begin
      @(negedge avl_clk);
      chk("rw_exclusive", {31'd0, s_read & s_write}, 0);
      chk("busy_vs_grant", {31'd0, busy}, {31'd0, grant != 2'b00});
      chk("busy_vs_state", {31'd0, busy}, {31'd0, fsm_state != 2'd0});
      chk("grant_onehot", {31'd0, grant == 2'b11}, 0);
      chk("m0_nonowner_stall", {31'd0, ~grant[0] & ~m0_waitrequest}, 0);
      chk("m1_nonowner_stall", {31'd0, ~grant[1] & ~m1_waitrequest}, 0);
      chk("m0_rdata_pass", {24'd0, m0_readdata}, {24'd0, s_readdata});
      chk("m1_rdata_pass", {24'd0, m1_readdata}, {24'd0, s_readdata});
      if (!busy) chk("idle_no_strobe", {30'd0, s_read, s_write}, 0);
      if (prev_g == 2'b00 && grant != 2'b00) begin
        g = grant[1];
        grant_log.push_back(g);
        if (exp_grant_q.size() == 0) fail_now("grant_unexpected", $sformatf("grant %b", grant));
        else chk("grant_owner", {31'd0, g}, {31'd0, exp_grant_q.pop_front()});
        chk("owner_ready_first_cycle", {31'd0, g ? m1_waitrequest : m0_waitrequest}, 0);
      end
      prev_g = grant;
      if (s_write) begin
        wr_beats++;
        if (s_beginbursttransfer) begin_beats++;
        if (exp_wr_q.size() == 0) fail_now("wr_unexpected", $sformatf("addr %0h data %0h", s_address, s_writedata));
        else begin
          ew = exp_wr_q.pop_front();
          chk("wr_beat", {13'd0, s_address, s_writedata, s_beginbursttransfer}, {13'd0, ew});
        end
      end
      if (s_read) begin
        if (exp_rd_q.size() == 0) fail_now("rd_unexpected", $sformatf("addr %0h", s_address));
        else begin
          er = exp_rd_q.pop_front();
          chk("rd_cmd", {21'd0, s_address, s_beginbursttransfer}, {21'd0, er});
        end
      end
      if (m0_readdatavalid) begin
        rdv_pulses++;
        if (exp_m0_q.size() == 0) fail_now("m0_rdv_unexpected", $sformatf("data %0h", m0_readdata));
        else chk("m0_return", {24'd0, m0_readdata}, {24'd0, exp_m0_q.pop_front()});
      end
      if (m1_readdatavalid) begin
        rdv_pulses++;
        if (exp_m1_q.size() == 0) fail_now("m1_rdv_unexpected", $sformatf("data %0h", m1_readdata));
        else chk("m1_return", {24'd0, m1_readdata}, {24'd0, exp_m1_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_m(input int n, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] bc, input logic beg);
    if (n == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
      m0_burstcount = bc; m0_beginbursttransfer = beg;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
      m1_burstcount = bc; m1_beginbursttransfer = beg;
    end
  endtask

  // Wait until the current command/beat of master n is accepted.
  task automatic wait_accept(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge avl_clk);
      if (!(n == 0 ? m0_waitrequest : m1_waitrequest)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("accept_timeout", $sformatf("master %0d", n));
    @(posedge avl_clk);
    #1;
  endtask

  task automatic m_read(input int n, input logic [AW-1:0] a, input logic [BW-1:0] bc, input logic beg);
    set_m(n, 1'b1, 1'b0, a, '0, bc, beg);
    wait_accept(n);
    set_m(n, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic m_write(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d, input int nbeats,
                         input logic [BW-1:0] bc, input logic beg, input int gap_at, input int gap_len);
    for (int i = 0; i < nbeats; i++) begin
      if (i == gap_at && gap_len > 0) begin
        set_m(n, 1'b0, 1'b0, '0, '0, bc, beg);
        repeat (gap_len) @(posedge avl_clk);
        #1;
      end
      set_m(n, 1'b0, 1'b1, a + AW'(i), d + DW'(i), bc, beg);
      wait_accept(n);
    end
    set_m(n, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge avl_clk);
      if (!busy && exp_wr_q.size() == 0 && exp_rd_q.size() == 0 && exp_m0_q.size() == 0 &&
          exp_m1_q.size() == 0 && exp_grant_q.size() == 0 && slv_rd_q.size() == 0) break;
    end
    chk({tag, "_drained"}, {31'd0, i < 300}, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, {30'd0, grant}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_s_strobes"}, {29'd0, s_read, s_write, s_beginbursttransfer}, 0);
    chk({tag, "_waitreq"}, {30'd0, m0_waitrequest, m1_waitrequest}, 32'h3);
    chk({tag, "_rdv"}, {30'd0, m0_readdatavalid, m1_readdatavalid}, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w0, b0, r0, acc;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    set_m(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    set_m(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    avl_rst = 1'b1;
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(negedge avl_clk);
    avl_rst = 1'b0;
    @(posedge avl_clk);
    #1;

    // Tie after reset: m0 first; m0 re-requests at once, so the next tie goes to m1.
    grant_log.delete();
    exp_grant_q.push_back(1'b0); exp_grant_q.push_back(1'b1); exp_grant_q.push_back(1'b0);
    exp_rd_q.push_back({10'h200, 1'b0}); exp_rd_q.push_back({10'h202, 1'b0}); exp_rd_q.push_back({10'h201, 1'b0});
    exp_m0_q.push_back(8'h11); exp_m0_q.push_back(8'h22);
    exp_m1_q.push_back(8'h33);
    fork
      begin m_read(0, 10'h200, 10'd1, 1'b0); m_read(0, 10'h201, 10'd1, 1'b0); end
      begin m_read(1, 10'h202, 10'd1, 1'b0); end
    join
    wait_done("tie");
    if (grant_log.size() == 3) chk("tie_order", {29'd0, grant_log[0], grant_log[1], grant_log[2]}, 32'b010);
    else fail_now("tie_order", $sformatf("%0d grants logged, 3 required", grant_log.size()));

    // Single write then readback through m0.
    w0 = wr_beats;
    exp_grant_q.push_back(1'b0); exp_grant_q.push_back(1'b0);
    exp_wr_q.push_back({10'h005, 8'hA5, 1'b1});
    exp_rd_q.push_back({10'h005, 1'b0});
    exp_m0_q.push_back(8'hA5);
    m_write(0, 10'h005, 8'hA5, 1, 10'd1, 1'b0, -1, 0);
    @(negedge avl_clk);
    chk("single_write_idle", {31'd0, busy}, 0);
    m_read(0, 10'h005, 10'd1, 1'b0);
    wait_done("single");
    chk("single_write_beats", wr_beats - w0, 1);

    // m1 4-beat write burst with a 2-cycle gap; m0 contends and waits.
    w0 = wr_beats; b0 = begin_beats;
    exp_grant_q.push_back(1'b1); exp_grant_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) exp_wr_q.push_back({10'h020 + 10'(i), 8'h40 + 8'(i), i == 0});
    exp_wr_q.push_back({10'h030, 8'h77, 1'b1});
    fork
      m_write(1, 10'h020, 8'h40, 4, 10'd4, 1'b1, 2, 2);
      m_write(0, 10'h030, 8'h77, 1, 10'd1, 1'b0, -1, 0);
    join
    wait_done("burst_wr");
    chk("burst_wr_beats", wr_beats - w0, 5);
    chk("burst_wr_begins", begin_beats - b0, 2);

    // m0 3-beat read burst, then a stray readdatavalid in IDLE.
    exp_grant_q.push_back(1'b0);
    exp_rd_q.push_back({10'h010, 1'b1});
    exp_m0_q.push_back(8'h31); exp_m0_q.push_back(8'h32); exp_m0_q.push_back(8'h33);
    m_read(0, 10'h010, 10'd3, 1'b1);
    wait_done("burst_rd");
    r0 = rdv_pulses;
    @(negedge avl_clk);
    stray_req++;
    @(negedge avl_clk);
    chk("stray_rdv_blocked", {30'd0, m0_readdatavalid, m1_readdatavalid}, 0);
    repeat (2) @(negedge avl_clk);
    chk("stray_rdv_count", rdv_pulses - r0, 0);

    // burstcount 0 with begin set behaves as a single beat.
    exp_grant_q.push_back(1'b1); exp_grant_q.push_back(1'b1);
    exp_wr_q.push_back({10'h040, 8'h5C, 1'b1});
    exp_rd_q.push_back({10'h040, 1'b1});
    exp_m1_q.push_back(8'h5C);
    m_write(1, 10'h040, 8'h5C, 1, 10'd0, 1'b1, -1, 0);
    @(negedge avl_clk);
    chk("bcnt0_write_idle", {31'd0, busy}, 0);
    m_read(1, 10'h040, 10'd0, 1'b1);
    wait_done("bcnt0");

    // Reset after 2 of 5 write beats; m1's pending read is served afterwards.
    exp_grant_q.push_back(1'b0); exp_grant_q.push_back(1'b1);
    exp_wr_q.push_back({10'h100, 8'h60, 1'b1}); exp_wr_q.push_back({10'h101, 8'h61, 1'b0});
    exp_rd_q.push_back({10'h005, 1'b0});
    exp_m1_q.push_back(8'hA5);
    fork
      m_read(1, 10'h005, 10'd1, 1'b0);
      begin
        acc = 0; wa = 10'h100; wd = 8'h60;
        set_m(0, 1'b0, 1'b1, wa, wd, 10'd5, 1'b1);
        for (int k = 0; k < 100 && acc < 2; k++) begin
          @(negedge avl_clk);
          if (!m0_waitrequest) begin
            @(posedge avl_clk);
            #1;
            acc++; wa = wa + 10'd1; wd = wd + 8'd1;
            set_m(0, 1'b0, 1'b1, wa, wd, 10'd5, 1'b1);
          end else begin
            @(posedge avl_clk);
            #1;
          end
        end
        chk("mid_reset_pre_busy", {31'd0, busy}, 1);
        #3;
        avl_rst = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        set_m(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        repeat (2) @(negedge avl_clk);
        avl_rst = 1'b0;
      end
    join
    wait_done("mid_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
